contador_arbitrario_nand: RTL and testbench



---
 rtl/contador_arbitrario_nand.sv | 140 ++++++++++++++
 tb/tb_contador_arbitrario_nand.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/contador_arbitrario_nand.sv
// Eleven-state JK counter (0,2,3,5,6,7,10,12,14,15,4) with NAND-only excitation.
// ARB_CNT_SELF_CORRECT_EN sends unused states to 0; otherwise to the next higher sequence state.

module jk_ff (
   input  logic C,
   input  logic Rn,
   input  logic J,
   input  logic K,
   output logic Q
);
   always_ff @(posedge C or negedge Rn) begin
      if (!Rn) begin
         Q <= 1'b0;
      end else begin
         case ({J, K})
            2'b00:   Q <= Q;
            2'b01:   Q <= 1'b0;
            2'b10:   Q <= 1'b1;
            default: Q <= ~Q;
         endcase
      end
   end
endmodule

module contador_arbitrario_nand (
   input  logic       C,
   input  logic       Rn,
   output logic [3:0] Q
);
   logic j3, k3, j2, k2, j1, k1, j0, k0;
   logic na, nb, nd;
   logic t0, j0_n, u, nor_ab;
   logic p2, p3, p12, p12a;
   logic bc_n, bc, bcd_n, bcd;

   // a=Q[3], b=Q[2], c=Q[1], d=Q[0]; inverters are tied-input NANDs
   nand g_na (na, Q[3], Q[3]);
   nand g_nb (nb, Q[2], Q[2]);
   nand g_nd (nd, Q[0], Q[0]);

   // J0 = c & (~a | b)
   nand g_t0   (t0, Q[3], nb);
   nand g_j0n  (j0_n, Q[1], t0);
   nand g_j0   (j0, j0_n, j0_n);

   // K0 = a | b | ~c
   nand g_u    (u, na, nb);
   nand g_nab  (nor_ab, u, u);
   nand g_k0   (k0, nor_ab, Q[1]);

   // K1 = a~b | ad | ~bd
   nand g_p2   (p2, Q[3], Q[0]);
   nand g_p3   (p3, nb, Q[0]);
   nand g_p12  (p12, t0, p2);
   nand g_p12a (p12a, p12, p12);
   nand g_k1   (k1, p12a, p3);

   // J3 = b & c & d
   nand g_bcn  (bc_n, Q[2], Q[1]);
   nand g_bc   (bc, bc_n, bc_n);
   nand g_bcdn (bcd_n, bc, Q[0]);
   nand g_bcd  (bcd, bcd_n, bcd_n);
   nand g_j3   (j3, bcd_n, bcd_n);

`ifdef ARB_CNT_SELF_CORRECT_EN
   logic nc;
   logic m_bd, y1, y2, xor_bd, xnor_bd, t1a_n, ab_n, ab, t2a_n;
   logic m_ad, z1, z2, xor_ad, j2_n;
   logic m_cd, w1, w2, xor_cd, xnor_cd, t1b_n, ac_n, acd, t2b_n;
   logic or_bc;

   nand g_nc (nc, Q[1], Q[1]);

   // J1 = ~a(b xnor d) | ab~d
   nand g_mbd  (m_bd, Q[2], Q[0]);
   nand g_y1   (y1, Q[2], m_bd);
   nand g_y2   (y2, Q[0], m_bd);
   nand g_xbd  (xor_bd, y1, y2);
   nand g_xnbd (xnor_bd, xor_bd, xor_bd);
   nand g_t1a  (t1a_n, na, xnor_bd);
   nand g_abn  (ab_n, Q[3], Q[2]);
   nand g_ab   (ab, ab_n, ab_n);
   nand g_t2a  (t2a_n, ab, nd);
   nand g_j1   (j1, t1a_n, t2a_n);

   // J2 = c(a xor d)
   nand g_mad  (m_ad, Q[3], Q[0]);
   nand g_z1   (z1, Q[3], m_ad);
   nand g_z2   (z2, Q[0], m_ad);
   nand g_xad  (xor_ad, z1, z2);
   nand g_j2n  (j2_n, Q[1], xor_ad);
   nand g_j2   (j2, j2_n, j2_n);

   // K2 = ~a(c xnor d) | a~cd
   nand g_mcd  (m_cd, Q[1], Q[0]);
   nand g_w1   (w1, Q[1], m_cd);
   nand g_w2   (w2, Q[0], m_cd);
   nand g_xcd  (xor_cd, w1, w2);
   nand g_xncd (xnor_cd, xor_cd, xor_cd);
   nand g_t1b  (t1b_n, na, xnor_cd);
   nand g_acn  (ac_n, Q[3], nc);
   nand g_ac   (acd, ac_n, ac_n);
   nand g_t2b  (t2b_n, acd, Q[0]);
   nand g_k2   (k2, t1b_n, t2b_n);

   // K3 = d | ~b~c, so 8/9/11/13/15 all leave the upper half
   nand g_obc  (or_bc, nb, nc);
   nand g_k3   (k3, nd, or_bc);
`else
   logic x_n, x, o_ad, j2_n;
   logic m_cd, w1, w2, xor_cd, xnor_cd, k2_n;

   // J1 = a | ~b | d
   nand g_xn   (x_n, na, Q[2]);
   nand g_x    (x, x_n, x_n);
   nand g_j1   (j1, x, nd);

   // J2 = c(a | d)
   nand g_oad  (o_ad, nd, na);
   nand g_j2n  (j2_n, Q[1], o_ad);
   nand g_j2   (j2, j2_n, j2_n);

   // K2 = ~a(c xnor d)
   nand g_mcd  (m_cd, Q[1], Q[0]);
   nand g_w1   (w1, Q[1], m_cd);
   nand g_w2   (w2, Q[0], m_cd);
   nand g_xcd  (xor_cd, w1, w2);
   nand g_xncd (xnor_cd, xor_cd, xor_cd);
   nand g_k2n  (k2_n, na, xnor_cd);
   nand g_k2   (k2, k2_n, k2_n);

   // MSB toggles on 7 and 15 only
   nand g_k3   (k3, bcd_n, bcd_n);
`endif

   jk_ff JK3 (.C(C), .Rn(Rn), .J(j3), .K(k3), .Q(Q[3]));
   jk_ff JK2 (.C(C), .Rn(Rn), .J(j2), .K(k2), .Q(Q[2]));
   jk_ff JK1 (.C(C), .Rn(Rn), .J(j1), .K(k1), .Q(Q[1]));
   jk_ff JK0 (.C(C), .Rn(Rn), .J(j0), .K(k0), .Q(Q[0]));
endmodule

// File: tb/tb_contador_arbitrario_nand.sv
// Bench for contador_arbitrario_nand: sequence, forced unused states, async reset, random walks.
`timescale 1ns/100ps

module tb_contador_arbitrario_nand;
   logic       C = 1'b0;
   logic       Rn = 1'b1;
   logic [3:0] Q;
   logic [3:0] force_val;
   logic [3:0] exp_q;
   int         vectors = 0;
   int         errors = 0;
   int         main_seq [11] = '{0, 2, 3, 5, 6, 7, 10, 12, 14, 15, 4};

   contador_arbitrario_nand dut (.C(C), .Rn(Rn), .Q(Q));

   always #1 C = ~C;

   // Reference: position in the listed main cycle, or recovery rule for unused codes
   function automatic logic [3:0] model_next(input logic [3:0] s);
      int best;
      best = 16;
      for (int i = 0; i < 11; i++)
         if (main_seq[i] == int'(s)) return 4'(main_seq[(i + 1) % 11]);
`ifdef ARB_CNT_SELF_CORRECT_EN
      best = 0;
`else
      for (int i = 0; i < 11; i++)
         if (main_seq[i] > int'(s) && main_seq[i] < best) best = main_seq[i];
`endif
      return 4'(best);
   endfunction

   task automatic force_state(input logic [3:0] v);
      force_val = v;
      force dut.JK3.Q = force_val[3];
      force dut.JK2.Q = force_val[2];
      force dut.JK1.Q = force_val[1];
      force dut.JK0.Q = force_val[0];
      #0.1;
      release dut.JK3.Q;
      release dut.JK2.Q;
      release dut.JK1.Q;
      release dut.JK0.Q;
      #0.1;
   endtask

   task automatic test_reset();
      #0.2 Rn = 1'b0;
      #0.2;
      vectors++;
      if (Q !== 4'd0) begin
         errors++;
         $display("FAIL reset_async: Q=%0d expected 0", Q);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge C); @(negedge C);
         vectors++;
         if (Q !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold[%0d]: Q=%0d expected 0", i, Q);
         end
      end
      Rn = 1'b1;
      exp_q = 4'd0;
      for (int i = 0; i < 12; i++) begin
         @(posedge C); @(negedge C);
         exp_q = model_next(exp_q);
         vectors++;
         if (Q !== exp_q) begin
            errors++;
            $display("FAIL main_seq[%0d]: Q=%0d expected %0d", i, Q, exp_q);
         end
      end
   endtask

   task automatic test_unused_states();
      logic [3:0] list [5] = '{4'd1, 4'd8, 4'd9, 4'd11, 4'd13};
      for (int k = 0; k < 5; k++) begin
         @(negedge C);
         force_state(list[k]);
         exp_q = list[k];
         vectors++;
         if (Q !== exp_q) begin
            errors++;
            $display("FAIL force_%0d: Q=%0d expected %0d", list[k], Q, exp_q);
         end
         for (int i = 0; i < 12; i++) begin
            @(posedge C); @(negedge C);
            exp_q = model_next(exp_q);
            vectors++;
            if (Q !== exp_q) begin
               errors++;
               $display("FAIL recover_%0d[%0d]: Q=%0d expected %0d", list[k], i, Q, exp_q);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      int n;
      n = 0;
      while (Q !== 4'd12 && n < 30) begin
         @(posedge C); @(negedge C);
         n++;
      end
      vectors++;
      if (Q !== 4'd12) begin
         errors++;
         $display("FAIL reach_12: Q=%0d expected 12 within 30 cycles", Q);
      end
      #0.3 Rn = 1'b0;
      #0.2;
      vectors++;
      if (Q !== 4'd0) begin
         errors++;
         $display("FAIL mid_reset_async: Q=%0d expected 0", Q);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge C); @(negedge C);
         vectors++;
         if (Q !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_hold[%0d]: Q=%0d expected 0", i, Q);
         end
      end
      Rn = 1'b1;
      @(posedge C); @(negedge C);
      vectors++;
      if (Q !== 4'd2) begin
         errors++;
         $display("FAIL mid_reset_release: Q=%0d expected 2", Q);
      end
   endtask

   task automatic test_random_walk();
      int len;
      for (int t = 0; t < 20; t++) begin
         @(negedge C);
         exp_q = 4'($urandom_range(15));
         force_state(exp_q);
         len = $urandom_range(14, 3);
         for (int i = 0; i < len; i++) begin
            @(posedge C);
            if ($urandom_range(9) == 0) begin
               #0.4 Rn = 1'b0;
               exp_q = 4'd0;
               #0.2;
               vectors++;
               if (Q !== exp_q) begin
                  errors++;
                  $display("FAIL rand_reset[%0d.%0d]: Q=%0d expected 0", t, i, Q);
               end
               @(negedge C);
               Rn = 1'b1;
            end else begin
               exp_q = model_next(exp_q);
               @(negedge C);
               vectors++;
               if (Q !== exp_q) begin
                  errors++;
                  $display("FAIL rand_walk[%0d.%0d]: Q=%0d expected %0d", t, i, Q, exp_q);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_unused_states();
      test_mid_reset();
      test_random_walk();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
